// File: rtl/bsg_pkg.sv
// Shared definitions for the register serializer: register addresses,
// CONTROL bit positions, CONTROL write mask and FSM state encoding.
package bsg_pkg;

  // Default register addresses on the host bus
  localparam int unsigned BSG_ADDR_CTRL = 32'h10;
  localparam int unsigned BSG_ADDR_D0   = 32'h11;
  localparam int unsigned BSG_ADDR_D1   = 32'h12;

  // CONTROL register bit positions
  localparam int CTRL_BUSY  = 0;  // read-only, word in flight
  localparam int CTRL_DONE  = 1;  // read-only, sticky, cleared by an accepted START
  localparam int CTRL_START = 2;  // write-1 to start, always reads 0
  localparam int CTRL_LOOP  = 3;  // read/write, repeat the word

  // Only START and LOOP are writable
  localparam logic [7:0] CTRL_WMASK = 8'h0C;

  // Serializer sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } bsg_state_t;

endpackage

// File: rtl/bsg_tick_gen.sv
// Bit-rate prescaler: counts SYS_CLK cycles and raises tick for one cycle
// every CLK_DIV cycles. clear holds the count at zero so the first tick
// after clear is released lands exactly CLK_DIV cycles later.
module bsg_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic SYS_CLK,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int PRE_W = $clog2(CLK_DIV) + 1;
  localparam logic [PRE_W-1:0] LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] count;

  // Tick fires on the last count of each period, never while cleared
  assign tick = !clear && (count == LAST);

  // Prescaler count: restart on clear or at the end of each bit period
  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_reg_serializer.sv
// Host-side register serializer: a valid/ready register port holding
// CONTROL, DATA_0 and DATA_1, and an FSM that shifts {DATA_1,DATA_0}
// out LSB-first, one bit every CLK_DIV cycles, optionally looping.
module bsg_reg_serializer
  import bsg_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          CLK_DIV    = 4,
  parameter int unsigned ADDR_CTRL  = BSG_ADDR_CTRL,
  parameter int unsigned ADDR_D0    = BSG_ADDR_D0,
  parameter int unsigned ADDR_D1    = BSG_ADDR_D1
) (
  input  logic                  SYS_CLK,
  input  logic                  rst,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  rdata_valid,
  output logic                  bsg_bit,
  output logic                  bsg_bit_valid,
  output logic                  done_pulse,
  output bsg_state_t            state_dbg
);

  localparam int WORD_W   = 2 * DATA_WIDTH;
  localparam int BITCNT_W = $clog2(WORD_W) + 1;

  localparam logic [DATA_WIDTH-1:0] A_CTRL = ADDR_CTRL[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] A_D0   = ADDR_D0[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] A_D1   = ADDR_D1[DATA_WIDTH-1:0];
  localparam logic [BITCNT_W-1:0]   LAST_BIT = BITCNT_W'(WORD_W - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // wr_en, addr_in and data_in are sampled on that same edge. After every
  // transfer ready is low for exactly one cycle, so a host holding valid
  // high gets one transfer every two cycles.

  bsg_state_t            state;
  logic [DATA_WIDTH-1:0] data0;
  logic [DATA_WIDTH-1:0] data1;
  logic                  busy;
  logic                  done_flag;
  logic                  loop;
  logic [WORD_W-1:0]     shreg;
  logic [BITCNT_W-1:0]   bitcnt;
  logic                  tick;

  logic                  xfer;
  logic                  wr_xfer;
  logic                  rd_xfer;
  logic                  hit_ctrl;
  logic                  hit_d0;
  logic                  hit_d1;
  logic                  start_req;
  logic [DATA_WIDTH-1:0] ctrl_rd;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign state_dbg = state;

  assign xfer     = valid && ready;
  assign wr_xfer  = xfer && wr_en;
  assign rd_xfer  = xfer && !wr_en;
  assign hit_ctrl = (addr_in == A_CTRL);
  assign hit_d0   = (addr_in == A_D0);
  assign hit_d1   = (addr_in == A_D1);

  // START request seen on the bus; only honoured from IDLE by the FSM
  assign start_req = wr_xfer && hit_ctrl &&
                     data_in[CTRL_START] && CTRL_WMASK[CTRL_START];

  // Prescaler only runs while shifting; LOAD and IDLE hold it at zero
  bsg_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .SYS_CLK (SYS_CLK),
    .rst     (rst),
    .clear   (state != SHIFT),
    .tick    (tick)
  );

  // Bus turnaround: drop ready for one cycle after each accepted transfer
  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      ready <= 1'b1;
    end else begin
      ready <= !xfer;
    end
  end

  // DATA registers: written any time, picked up by the shifter only at LOAD
  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      data0 <= '0;
      data1 <= '0;
    end else if (wr_xfer) begin
      if (hit_d0) data0 <= data_in;
      if (hit_d1) data1 <= data_in;
    end
  end

  // CONTROL read view: START always reads 0, upper bits are 0
  always_comb begin
    ctrl_rd            = '0;
    ctrl_rd[CTRL_BUSY] = busy;
    ctrl_rd[CTRL_DONE] = done_flag;
    ctrl_rd[CTRL_LOOP] = loop;
  end

  // Read data select; unmapped addresses return 0
  always_comb begin
    rd_mux = '0;
    if (hit_ctrl)    rd_mux = ctrl_rd;
    else if (hit_d0) rd_mux = data0;
    else if (hit_d1) rd_mux = data1;
  end

  // Read return path: register the pre-edge value, pulse rdata_valid
  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= rd_xfer;
      if (rd_xfer) rdata_out <= rd_mux;
    end
  end

  // Serializer FSM with CONTROL flags and registered serial outputs
  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done_flag     <= 1'b0;
      loop          <= 1'b0;
      shreg         <= '0;
      bitcnt        <= '0;
      bsg_bit       <= 1'b0;
      bsg_bit_valid <= 1'b0;
      done_pulse    <= 1'b0;
    end else begin
      bsg_bit_valid <= 1'b0;
      done_pulse    <= 1'b0;

      // LOOP is writable in every state, including while busy
      if (wr_xfer && hit_ctrl) begin
        loop <= data_in[CTRL_LOOP] && CTRL_WMASK[CTRL_LOOP];
      end

      case (state)
        IDLE: begin
          if (start_req) begin
            state     <= LOAD;
            busy      <= 1'b1;
            done_flag <= 1'b0;
          end
        end

        LOAD: begin
          shreg  <= {data1, data0};
          bitcnt <= '0;
          state  <= SHIFT;
        end

        SHIFT: begin
          if (tick) begin
            bsg_bit       <= shreg[0];
            bsg_bit_valid <= 1'b1;
            shreg         <= shreg >> 1;
            bitcnt        <= bitcnt + 1'b1;
            // Loop decision uses LOOP as it stands at the last bit
            if (bitcnt == LAST_BIT) begin
              state <= loop ? LOAD : DONE;
            end
          end
        end

        DONE: begin
          done_pulse <= 1'b1;
          done_flag  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
